// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into 32-bit words and streams them to instruction memory.
// Define ENCODER_ILLEGAL_CHECK_EN to drop illegal opcodes and raise a sticky err flag.
module instruction_encoder #(
    parameter int bus = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [bus-1:0] base_addr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_last,
    input  logic [1:0]     FUNTYPE,
    input  logic [1:0]     FUNCODE,
    input  logic [3:0]     rd,
    input  logic [3:0]     ra,
    input  logic [3:0]     rb,
    input  logic [14:0]    imm,
    input  logic           imm_sel,
    output logic           imem_we,
    input  logic           imem_ready,
    output logic [bus-1:0] imem_addr,
    output logic [31:0]    imem_wdata,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [15:0]    count
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t         state;
    logic [bus-1:0] next_addr;
    logic [1:0]     rst_sync;
    logic           rst_int_n;
    logic           accept;
    logic           commit;
    logic           write_word;

    // Assertion is immediate; release waits two clock edges so no flop sees a half-released reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign in_ready = (state == RUN) && (!imem_we || imem_ready);
    assign accept   = in_valid && in_ready;
    assign commit   = imem_we && imem_ready;

`ifdef ENCODER_ILLEGAL_CHECK_EN
    function automatic logic is_legal(input logic [3:0] op);
        return !(op == 4'b0110 || op == 4'b0111 || op == 4'b1010 || op == 4'b1011);
    endfunction
    assign write_word = accept && is_legal({FUNTYPE, FUNCODE});
`else
    assign write_word = accept;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            next_addr  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef ENCODER_ILLEGAL_CHECK_EN
            err        <= 1'b0;
`endif
        end else begin
            if (commit && count != 16'hFFFF) count <= count + 16'd1;

            // A new word replaces a committing one in the same cycle, giving gap-free writes.
            if (write_word) begin
                imem_we    <= 1'b1;
                imem_addr  <= next_addr;
                imem_wdata <= {FUNTYPE, FUNCODE, rd, ra, rb, imm, imm_sel};
                next_addr  <= next_addr + bus'(4);
            end else if (commit) begin
                imem_we <= 1'b0;
            end

`ifdef ENCODER_ILLEGAL_CHECK_EN
            if (accept && !write_word) err <= 1'b1;
`endif

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        next_addr <= base_addr;
                        count     <= '0;
`ifdef ENCODER_ILLEGAL_CHECK_EN
                        err       <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (accept && in_last) state <= FLUSH;
                end
                FLUSH: begin
                    if (!imem_we || commit) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: stimulus pushes expected writes, a monitor pops them on commit.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [1:0]  FUNTYPE = '0;
    logic [1:0]  FUNCODE = '0;
    logic [3:0]  rd = '0, ra = '0, rb = '0;
    logic [14:0] imm = '0;
    logic        imm_sel = 1'b0;
    logic        imem_we;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy, done, err;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_queue[$];

`ifdef ENCODER_ILLEGAL_CHECK_EN
    localparam bit illegal_check = 1'b1;
`else
    localparam bit illegal_check = 1'b0;
`endif

    instruction_encoder #(.bus(32)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .FUNTYPE(FUNTYPE), .FUNCODE(FUNCODE), .rd(rd), .ra(ra), .rb(rb),
        .imm(imm), .imm_sel(imm_sel), .imem_we(imem_we), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Pops one expected word for every commit seen on the memory port.
    always @(negedge clk) begin
        if (imem_we && imem_ready) begin
            if (sb_queue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write actual addr=0x%08h data=0x%08h required none",
                         imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = sb_queue.pop_front();
                check_output("write_addr", imem_addr, e[63:32]);
                check_output("write_data", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic pulse_start(input logic [31:0] base);
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [3:0] r_d, input logic [3:0] r_a,
                                  input logic [3:0] r_b, input logic [14:0] im, input logic sel,
                                  input logic last, input bit expect_write,
                                  input logic [31:0] exp_addr, input logic [31:0] exp_data);
        bit accepted = 0;
        {FUNTYPE, FUNCODE} = op;
        rd = r_d; ra = r_a; rb = r_b; imm = im; imm_sel = sel; in_last = last;
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1;
                if (expect_write) sb_queue.push_back({exp_addr, exp_data});
                @(posedge clk);
                break;
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual in_ready=0 required 1");
        end
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input logic [15:0] exp_count, input logic exp_err);
        bit seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check_output("done_seen", 32'(seen), 32'd1);
        check_output("count", 32'(count), 32'(exp_count));
        check_output("err", 32'(err), 32'(exp_err));
        check_output("queue_drained", sb_queue.size(), 32'd0);
        @(negedge clk);
        check_output("idle_busy", 32'(busy), 32'd0);
        check_output("idle_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        check_output("rst_imem_we", 32'(imem_we), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_addr", imem_addr, 32'd0);
        check_output("rst_wdata", imem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single ADD word at address zero.
        pulse_start(32'h0);
        apply_stimulus(4'b0000, 4'd1, 4'd1, 4'd2, 15'd0, 1'b0, 1'b1, 1, 32'h0, 32'h01120000);
        wait_done(16'd1, 1'b0);

        // LDR then SHK back-to-back from 0xC.
        pulse_start(32'hC);
        apply_stimulus(4'b0100, 4'd1, 4'd1, 4'd2, 15'd5, 1'b1, 1'b0, 1, 32'hC, 32'h4112000B);
        apply_stimulus(4'b1111, 4'd1, 4'd1, 4'd2, 15'd0, 1'b0, 1'b1, 1, 32'h10, 32'hF1120000);
        wait_done(16'd2, 1'b0);

        // Memory stalls for three cycles; pending word must hold steady.
        imem_ready = 1'b0;
        pulse_start(32'h200);
        apply_stimulus(4'b0000, 4'd1, 4'd1, 4'd2, 15'd0, 1'b0, 1'b0, 1, 32'h200, 32'h01120000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("stall_we", 32'(imem_we), 32'd1);
            check_output("stall_in_ready", 32'(in_ready), 32'd0);
            check_output("stall_addr", imem_addr, 32'h200);
            check_output("stall_wdata", imem_wdata, 32'h01120000);
        end
        @(posedge clk);
        #1 imem_ready = 1'b1;
        apply_stimulus(4'b0001, 4'd3, 4'd4, 4'd5, 15'd0, 1'b0, 1'b1, 1, 32'h204, 32'h13450000);
        wait_done(16'd2, 1'b0);

        // Illegal opcode 1010 in the middle of a stream; a stray start in RUN is ignored.
        pulse_start(32'h100);
        pulse_start(32'h500);
        apply_stimulus(4'b0000, 4'd1, 4'd1, 4'd2, 15'd0, 1'b0, 1'b0, 1, 32'h100, 32'h01120000);
        apply_stimulus(4'b1010, 4'd1, 4'd1, 4'd2, 15'd0, 1'b0, 1'b0, !illegal_check, 32'h104, 32'hA1120000);
        apply_stimulus(4'b0001, 4'd1, 4'd1, 4'd2, 15'd0, 1'b0, 1'b1, 1,
                       illegal_check ? 32'h104 : 32'h108, 32'h11120000);
        wait_done(illegal_check ? 16'd2 : 16'd3, illegal_check);

        // Reset while a write is stalled: outputs clear at once and the word is lost.
        imem_ready = 1'b0;
        pulse_start(32'h300);
        apply_stimulus(4'b0000, 4'd1, 4'd1, 4'd2, 15'd0, 1'b0, 1'b0, 0, 32'h0, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_output("midrst_we", 32'(imem_we), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_in_ready", 32'(in_ready), 32'd0);
        check_output("midrst_addr", imem_addr, 32'd0);
        check_output("midrst_wdata", imem_wdata, 32'd0);
        check_output("midrst_count", 32'(count), 32'd0);
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        pulse_start(32'h400);
        apply_stimulus(4'b0000, 4'd1, 4'd1, 4'd2, 15'd0, 1'b0, 1'b1, 1, 32'h400, 32'h01120000);
        wait_done(16'd1, 1'b0);

        // Address wraps past the top of the address space.
        pulse_start(32'hFFFFFFFC);
        apply_stimulus(4'b0010, 4'd7, 4'd0, 4'd0, 15'd0, 1'b0, 1'b0, 1, 32'hFFFFFFFC, 32'h27000000);
        apply_stimulus(4'b1000, 4'd0, 4'd0, 4'd0, 15'h7FFF, 1'b1, 1'b1, 1, 32'h00000000, 32'h8000FFFF);
        wait_done(16'd2, 1'b0);

        check_output("final_queue_empty", sb_queue.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
